// File: rtl/feeder_pkg.sv
// Shared defaults and width helpers for the data window feeder and its scratchpad.
package feeder_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_WIN    = 4;
  localparam int DEF_STRIDE = 1;

  localparam int PTR_W = $clog2(DEF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/spad_regfile.sv
// Register-array scratchpad: one synchronous write port, one asynchronous read port.
module spad_regfile
  import feeder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array is small and flop-based, so it is reset like any other
  // state; a RAM macro would not be, and consumers must not rely on it then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_window_feeder.sv
// Buffers an element stream and serves it as overlapping windows of WIN elements,
// sliding STRIDE elements per completed window; also drives the control unit status.
module data_window_feeder
  import feeder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WIN    = DEF_WIN,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              clr_addr,
  input  logic              read_spad,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              wait_data,
  output logic              valid_start_addr,
  output logic              at_end_data
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] WIN_C    = CW'(WIN);
  localparam logic [CW-1:0] STRIDE_C = CW'(STRIDE);
  localparam logic [AW-1:0] WIN_M1   = AW'(WIN - 1);
  localparam logic [AW-1:0] STRIDE_P = AW'(STRIDE);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] ws_q, ws_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_seen_q, last_seen_d;

  logic          short_q;
  logic          on_win_end;
  logic          do_write;
  logic          do_read;
  logic          win_done;

  assign short_q    = (count_q < WIN_C);
  assign on_win_end = (rd_ptr_q == ws_q + WIN_M1);

  assign in_ready         = (count_q < DEPTH_C) & ~last_seen_q;
  assign wait_data        = short_q & ~last_seen_q;
  assign valid_start_addr = (rd_ptr_q != ws_q);
  // count >= WIN guarantees the subtraction cannot wrap.
  assign at_end_data      = last_seen_q & ((count_q - STRIDE_C) < WIN_C) & on_win_end & ~short_q;

  // Reads are refused both while waiting and once drained; both imply count < WIN.
  assign do_write = in_valid & in_ready & ~init;
  assign do_read  = read_spad & ~short_q & ~init & ~clr_addr;
  assign win_done = do_read & on_win_end;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    ws_d        = ws_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_seen_d = last_seen_q;

    if (init) begin
      wr_ptr_d    = '0;
      ws_d        = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      last_seen_d = 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (in_last) begin
          last_seen_d = 1'b1;
        end
      end

      if (clr_addr) begin
        rd_ptr_d = ws_q;
      end else if (win_done) begin
        ws_d     = ws_q + STRIDE_P;
        rd_ptr_d = ws_q + STRIDE_P;
      end else if (do_read) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end

      count_d = count_q + CW'(do_write) - (win_done ? STRIDE_C : '0);
    end
  end

  // NOTE: state registers use non-blocking assignments only; all next-state
  // math lives in the always_comb above so ordering never matters here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      ws_q        <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_seen_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      ws_q        <= ws_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_seen_q <= last_seen_d;
    end
  end

  spad_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_spad (
    .clk   (clk),
    .rst   (rst),
    .we    (do_write),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

endmodule
